// File: rtl/ultra_distance_calc_if.sv
// Handshake bundle between the ultrasonic echo counter and the distance calculator.
// master = counter side (count/calculate), slave = calculator side (results/restart).
interface ultra_distance_calc_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic [CNT_W-1:0] count;
    logic             calculate;
    logic             counter_rst;
    logic [7:0]       distance;
    logic             dist_valid;
    logic             out_of_range;
    logic [7:0]       avg_distance;
    logic             avg_valid;

    modport master (
        output count, calculate,
        input  counter_rst, distance, dist_valid, out_of_range, avg_distance, avg_valid
    );

    modport slave (
        input  count, calculate,
        output counter_rst, distance, dist_valid, out_of_range, avg_distance, avg_valid
    );
endinterface

// File: rtl/ultra_distance_calc.sv
// Converts a finished echo-width count into a saturated 8-bit distance, range-checks it,
// keeps a moving average of in-range samples and re-arms the counter afterwards.
module ultra_distance_calc #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SCALE_NUM   = 1,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned MIN_CNT     = 2,
    parameter int unsigned MAX_CNT     = 200,
    parameter int unsigned AVG_LOG2    = 2
) (
    input logic                  CLKOUT,
    input logic                  reset,
    ultra_distance_calc_if.slave bus
);
    localparam int unsigned Depth = 1 << AVG_LOG2;
    localparam int unsigned SumW  = 8 + AVG_LOG2;
    localparam int unsigned ProdW = CNT_W + 16;
    localparam int unsigned FillW = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        StIdle, StCapture, StScale, StSat, StCheck, StRearm
    } state_e;

    state_e               state_q, state_d;
    logic                 calc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [ProdW-1:0]     prod_q;
    logic [7:0]           sat_q;
    logic [7:0]           distance_q;
    logic                 oor_q;
    logic                 dist_valid_q;
    logic                 counter_rst_q;
    logic [7:0]           avg_q;
    logic                 avg_valid_q;
    logic [7:0]           buf_q [Depth];
    logic [SumW-1:0]      sum_q;
    logic [AVG_LOG2-1:0]  wp_q;
    logic [FillW-1:0]     fill_q;

    logic                 start;
    logic [ProdW-1:0]     scaled;
    logic [7:0]           sat_d;
    logic                 oor_d;
    logic [SumW-1:0]      sum_d;
    logic [FillW-1:0]     fill_d;

    always_comb begin
        state_d = state_q;
        start   = bus.calculate & ~calc_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCapture;
            StCapture: state_d = StScale;
            StScale:   state_d = StSat;
            StSat:     state_d = StCheck;
            StCheck:   state_d = StRearm;
            StRearm:   if (!bus.calculate) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        scaled = prod_q >> SCALE_SHIFT;
        sat_d  = (|scaled[ProdW-1:8]) ? 8'hff : scaled[7:0];
        oor_d  = (32'(cnt_q) < MIN_CNT) || (32'(cnt_q) > MAX_CNT);
        // Empty slots hold 0, so subtracting the old entry before the buffer fills is harmless.
        sum_d  = sum_q - {{AVG_LOG2{1'b0}}, buf_q[wp_q]} + {{AVG_LOG2{1'b0}}, distance_q};
        fill_d = (fill_q == FillW'(Depth)) ? fill_q : fill_q + 1'b1;
    end

    always_ff @(posedge CLKOUT) begin
        if (reset) begin
            state_q       <= StIdle;
            calc_q        <= 1'b1;
            cnt_q         <= '0;
            prod_q        <= '0;
            sat_q         <= '0;
            distance_q    <= '0;
            oor_q         <= 1'b0;
            dist_valid_q  <= 1'b0;
            counter_rst_q <= 1'b0;
            avg_q         <= '0;
            avg_valid_q   <= 1'b0;
            sum_q         <= '0;
            wp_q          <= '0;
            fill_q        <= '0;
            for (int i = 0; i < int'(Depth); i++) buf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            calc_q        <= bus.calculate;
            dist_valid_q  <= 1'b0;
            avg_valid_q   <= 1'b0;
            counter_rst_q <= (state_d == StRearm);
            case (state_q)
                StIdle:    if (state_d == StCapture) cnt_q <= bus.count;
                StCapture: prod_q <= ProdW'(cnt_q) * ProdW'(SCALE_NUM);
                // Clamp gets its own cycle so the multiply and the saturate do not chain.
                StScale:   sat_q <= sat_d;
                StSat: begin
                    distance_q   <= sat_q;
                    oor_q        <= oor_d;
                    dist_valid_q <= 1'b1;
                end
                StCheck: begin
                    if (!oor_q) begin
                        buf_q[wp_q] <= distance_q;
                        sum_q       <= sum_d;
                        wp_q        <= wp_q + 1'b1;
                        fill_q      <= fill_d;
                        if (fill_d == FillW'(Depth)) begin
                            avg_q       <= sum_d[SumW-1:AVG_LOG2];
                            avg_valid_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.counter_rst  = counter_rst_q;
    assign bus.distance     = distance_q;
    assign bus.dist_valid   = dist_valid_q;
    assign bus.out_of_range = oor_q;
    assign bus.avg_distance = avg_q;
    assign bus.avg_valid    = avg_valid_q;
endmodule

// File: tb/tb_ultra_distance_calc.sv
// Randomized bench: two calculators (scale 1 and scale 17) run in lockstep against a
// queue-based model of distance, range check and 4-sample moving average.
module tb_ultra_distance_calc;
    logic CLKOUT = 1'b0;
    logic reset;
    always #5 CLKOUT = ~CLKOUT;

    ultra_distance_calc_if #(.CNT_W(8)) bus_a ();
    ultra_distance_calc_if #(.CNT_W(8)) bus_b ();

    ultra_distance_calc u_dut_a (
        .CLKOUT (CLKOUT),
        .reset  (reset),
        .bus    (bus_a)
    );

    ultra_distance_calc #(.SCALE_NUM(17)) u_dut_b (
        .CLKOUT (CLKOUT),
        .reset  (reset),
        .bus    (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hist_a[$];
    int hist_b[$];
    int avg_a = 0;
    int avg_b = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] c, input logic calc);
        bus_a.count = c;
        bus_b.count = c;
        bus_a.calculate = calc;
        bus_b.calculate = calc;
    endtask

    task automatic set_calc(input logic calc);
        bus_a.calculate = calc;
        bus_b.calculate = calc;
    endtask

    task automatic step();
        @(posedge CLKOUT);
        #1;
    endtask

    function automatic int ref_dist(input int cnt, input int num);
        int d;
        d = cnt * num;
        return (d > 255) ? 255 : d;
    endfunction

    function automatic bit ref_in_range(input int cnt);
        return (cnt >= 2) && (cnt <= 200);
    endfunction

    task automatic clear_model();
        hist_a.delete();
        hist_b.delete();
        avg_a = 0;
        avg_b = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_dist_a"}, bus_a.distance, 0);
        check_eq({tag, "_dv_a"}, bus_a.dist_valid, 0);
        check_eq({tag, "_oor_a"}, bus_a.out_of_range, 0);
        check_eq({tag, "_avg_a"}, bus_a.avg_distance, 0);
        check_eq({tag, "_av_a"}, bus_a.avg_valid, 0);
        check_eq({tag, "_crst_a"}, bus_a.counter_rst, 0);
        check_eq({tag, "_dist_b"}, bus_b.distance, 0);
        check_eq({tag, "_crst_b"}, bus_b.counter_rst, 0);
    endtask

    // One full measurement: calculate rises before edge k, results checked at k+3 and k+4,
    // restart held for 'hold' extra cycles, then calculate drops.
    task automatic measure(input int cnt, input int hold, input bit glitch);
        bit ok;
        int da, db, s;
        bit ava, avb;
        ok  = ref_in_range(cnt);
        da  = ref_dist(cnt, 1);
        db  = ref_dist(cnt, 17);
        ava = 1'b0;
        avb = 1'b0;
        if (ok) begin
            hist_a.push_back(da);
            hist_b.push_back(db);
            if (hist_a.size() > 4) void'(hist_a.pop_front());
            if (hist_b.size() > 4) void'(hist_b.pop_front());
            if (hist_a.size() == 4) begin
                s = 0;
                foreach (hist_a[i]) s += hist_a[i];
                avg_a = s / 4;
                ava = 1'b1;
            end
            if (hist_b.size() == 4) begin
                s = 0;
                foreach (hist_b[i]) s += hist_b[i];
                avg_b = s / 4;
                avb = 1'b1;
            end
        end

        @(negedge CLKOUT);
        drive(8'(cnt), 1'b1);
        step();  // k
        check_eq("k_crst", bus_a.counter_rst, 0);
        check_eq("k_dv", bus_a.dist_valid, 0);
        if (glitch) begin
            @(negedge CLKOUT);
            set_calc(1'b0);
        end
        step();  // k+1
        if (glitch) begin
            @(negedge CLKOUT);
            set_calc(1'b1);
        end
        step();  // k+2
        check_eq("k2_dv", bus_a.dist_valid, 0);
        step();  // k+3
        check_eq("k3_dv_a", bus_a.dist_valid, 1);
        check_eq("k3_dv_b", bus_b.dist_valid, 1);
        check_eq("k3_dist_a", bus_a.distance, da);
        check_eq("k3_dist_b", bus_b.distance, db);
        check_eq("k3_oor_a", bus_a.out_of_range, !ok);
        check_eq("k3_oor_b", bus_b.out_of_range, !ok);
        check_eq("k3_av", bus_a.avg_valid, 0);
        check_eq("k3_crst", bus_a.counter_rst, 0);
        step();  // k+4
        check_eq("k4_dv", bus_a.dist_valid, 0);
        check_eq("k4_crst_a", bus_a.counter_rst, 1);
        check_eq("k4_crst_b", bus_b.counter_rst, 1);
        check_eq("k4_av_a", bus_a.avg_valid, ava);
        check_eq("k4_av_b", bus_b.avg_valid, avb);
        check_eq("k4_avg_a", bus_a.avg_distance, avg_a);
        check_eq("k4_avg_b", bus_b.avg_distance, avg_b);
        check_eq("k4_dist_hold", bus_a.distance, da);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq("hold_crst", bus_a.counter_rst, 1);
            check_eq("hold_dv", bus_a.dist_valid, 0);
            check_eq("hold_av", bus_a.avg_valid, 0);
        end
        @(negedge CLKOUT);
        set_calc(1'b0);
        step();
        check_eq("drop_crst_a", bus_a.counter_rst, 0);
        check_eq("drop_crst_b", bus_b.counter_rst, 0);
        check_eq("drop_oor_hold", bus_a.out_of_range, !ok);
        check_eq("drop_avg_hold", bus_a.avg_distance, avg_a);
    endtask

    task automatic pulse_reset();
        @(negedge CLKOUT);
        reset = 1'b1;
        step();
        @(negedge CLKOUT);
        reset = 1'b0;
        clear_model();
    endtask

    // Reset lands while the sample is in the scale stage; a high calculate at release is ignored.
    task automatic reset_in_scale(input int cnt);
        @(negedge CLKOUT);
        drive(8'(cnt), 1'b1);
        step();  // k
        step();  // k+1, now scaling
        @(negedge CLKOUT);
        reset = 1'b1;
        step();
        check_all_zero("rst_scale");
        @(negedge CLKOUT);
        reset = 1'b0;
        clear_model();
        step();
        step();
        step();
        step();
        check_eq("rst_relaunch_dv", bus_a.dist_valid, 0);
        check_eq("rst_relaunch_crst", bus_a.counter_rst, 0);
        @(negedge CLKOUT);
        set_calc(1'b0);
        step();
    endtask

    initial begin
        reset = 1'b1;
        drive(8'd0, 1'b0);
        repeat (3) step();
        check_all_zero("reset");
        @(negedge CLKOUT);
        reset = 1'b0;
        step();
        check_all_zero("post_reset");

        measure(100, 2, 1'b0);
        pulse_reset();
        measure(10, 0, 1'b0);
        measure(20, 0, 1'b0);
        measure(30, 0, 1'b0);
        measure(40, 0, 1'b0);
        check_eq("avg_25", bus_a.avg_distance, 25);
        measure(50, 0, 1'b0);
        check_eq("avg_35", bus_a.avg_distance, 35);
        measure(1, 0, 1'b0);
        measure(201, 1, 1'b0);
        measure(200, 0, 1'b0);
        check_eq("sat_255", bus_b.distance, 255);
        measure(77, 20, 1'b1);
        reset_in_scale(60);
        measure(11, 0, 1'b0);
        measure(12, 0, 1'b0);
        measure(13, 0, 1'b0);
        measure(14, 0, 1'b0);
        measure(2, 0, 1'b0);
        measure(0, 0, 1'b0);

        repeat (60) begin
            measure(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
